// File: rtl/qosc_core_param.sv
// Quadrature oscillator core: rotates (re, im) by a complex coefficient per
// tick, with selectable tick source, burst/continuous run and saturation.
module qosc_core_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = 4,
    parameter int CNTW  = 8,
    parameter int DIVW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic                    ext_tick,
    input  logic [DIVW-1:0]         div,
    input  logic [CNTW-1:0]         burst_len,
    input  logic signed [WIDTH-1:0] re_coeff,
    input  logic signed [WIDTH-1:0] im_coeff,
    input  logic [SHW-1:0]          shift,
    input  logic signed [WIDTH-1:0] accu_re_init,
    input  logic signed [WIDTH-1:0] accu_im_init,
    output logic signed [WIDTH-1:0] accu_re,
    output logic signed [WIDTH-1:0] accu_im,
    output logic                    sample_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag,
    output logic [CNTW-1:0]         sample_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PW = 2 * WIDTH + 1;
    localparam logic signed [PW-1:0] MAXV =
        {{(PW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = ~MAXV;

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          sync;
    logic [DIVW-1:0]     div_cnt;
    logic [CNTW-1:0]     burst_q;
    logic [CNTW-1:0]     cnt_inc;
    logic                tick;
    logic                start_eff;
    logic                upd;
    logic                burst_end;
    logic signed [PW-1:0] ar;
    logic signed [PW-1:0] ai;
    logic signed [PW-1:0] cr;
    logic signed [PW-1:0] ci;
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;
    logic [WIDTH:0]      sat_re;
    logic [WIDTH:0]      sat_im;

    function automatic logic signed [PW-1:0] sx(
        input logic signed [WIDTH-1:0] v
    );
        return {{(PW - WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Returns {clamped, value}
    function automatic logic [WIDTH:0] sat(input logic signed [PW-1:0] v);
        if (v > MAXV) begin
            return {1'b1, MAXV[WIDTH-1:0]};
        end else if (v < MINV) begin
            return {1'b1, MINV[WIDTH-1:0]};
        end
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    always_comb begin
        tick = 1'b0;
        case (mode)
            2'd0:    tick = 1'b1;
            2'd1:    tick = sync[1] & ~sync[2];
            2'd2:    tick = (div_cnt == '0);
            default: tick = 1'b0;
        endcase
    end

    assign start_eff = start & ~stop & ~load & (state != RUN);
    assign upd       = (state == RUN) & tick & ~load & ~stop;
    assign cnt_inc   = sample_count + CNTW'(1);
    assign burst_end = (burst_q != '0) && (cnt_inc == burst_q);

    assign ar = sx(accu_re);
    assign ai = sx(accu_im);
    assign cr = sx(re_coeff);
    assign ci = sx(im_coeff);

    always_comb begin
        pr     = ar * cr - ai * ci;
        pi     = ar * ci + ai * cr;
        sat_re = sat(pr >>> shift);
        sat_im = sat(pi >>> shift);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else if (stop) begin
            if (state == RUN) state_nxt = IDLE;
        end else if (start_eff) begin
            state_nxt = RUN;
        end else if (upd && burst_end) begin
            state_nxt = DONE;
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[1:0], ext_tick};
        end
    end

    // Divider only runs in RUN; it is re-armed by every accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            burst_q <= '0;
        end else if (start_eff) begin
            div_cnt <= div;
            burst_q <= burst_len;
        end else if (state == RUN) begin
            div_cnt <= (div_cnt == '0) ? div : div_cnt - DIVW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            accu_re      <= '0;
            accu_im      <= '0;
            sample_count <= '0;
            sat_flag     <= 1'b0;
            sample_valid <= 1'b0;
        end else if (load) begin
            accu_re      <= accu_re_init;
            accu_im      <= accu_im_init;
            sample_count <= '0;
            sat_flag     <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (start_eff) begin
                sample_count <= '0;
            end else if (upd) begin
                accu_re      <= sat_re[WIDTH-1:0];
                accu_im      <= sat_im[WIDTH-1:0];
                sample_count <= cnt_inc;
                sample_valid <= 1'b1;
                sat_flag     <= sat_flag | sat_re[WIDTH] | sat_im[WIDTH];
            end
        end
    end

endmodule
